// File: rtl/sprite_pkg.sv
// Shared types and constants for the player missile bank and its slot sub-module.
package sprite_pkg;

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_t;

  localparam int unsigned SCREEN_ROWS = 480;
  localparam int unsigned SCREEN_COLS = 640;
  localparam int unsigned COORD_W     = 12;

  localparam logic [3:0] PIX_ON  = 4'hF;
  localparam logic [3:0] PIX_OFF = 4'h0;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/player_missile_bank_if.sv
// Pixel, player, fire and hit signals shared between the missile bank and its environment.
interface player_missile_bank_if #(
  parameter int unsigned N_MISSILES = 3
);
  import sprite_pkg::*;

  localparam int unsigned ID_W  = idx_w(N_MISSILES);
  localparam int unsigned CNT_W = idx_w(N_MISSILES + 1);

  logic [COORD_W-1:0]    pixel_row;
  logic [COORD_W-1:0]    pixel_column;
  logic [COORD_W-1:0]    player_col;
  logic                  fire_btn;
  logic                  hit_valid;
  logic [ID_W-1:0]       hit_id;
  logic [N_MISSILES-1:0] missile_active_vec;
  logic [3:0]            missile_output;
  logic                  fire_accepted;
  logic                  fire_dropped;
  logic [CNT_W-1:0]      in_flight;

  modport master (
    output pixel_row, pixel_column, player_col, fire_btn, hit_valid, hit_id,
    input  missile_active_vec, missile_output, fire_accepted, fire_dropped, in_flight
  );

  modport slave (
    input  pixel_row, pixel_column, player_col, fire_btn, hit_valid, hit_id,
    output missile_active_vec, missile_output, fire_accepted, fire_dropped, in_flight
  );

endinterface

// File: rtl/missile_slot.sv
// One missile slot: IDLE/FLY state, row/column position and pixel-in-sprite compare.
module missile_slot
  import sprite_pkg::*;
#(
  parameter int unsigned STEP        = 2,
  parameter int unsigned MISSILE_LEN = 3,
  parameter int unsigned LAUNCH_ROW  = 456,
  parameter int unsigned TOP_ROW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch,
  input  logic               tick,
  input  logic               hit,
  input  logic [COORD_W-1:0] launch_col,
  input  logic [COORD_W-1:0] pixel_row,
  input  logic [COORD_W-1:0] pixel_column,
  output logic               fly,
  output logic               active
);

  slot_state_t        state, state_nx;
  logic [COORD_W-1:0] row, row_nx;
  logic [COORD_W-1:0] col, col_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      row   <= COORD_W'(LAUNCH_ROW);
      col   <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
    end
  end

  // A hit outranks the tick move; retiring parks the slot at the launch row.
  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nx = FLY;
          row_nx   = COORD_W'(LAUNCH_ROW);
          col_nx   = launch_col;
        end
      end
      FLY: begin
        if (hit || (tick && (row < COORD_W'(TOP_ROW + STEP)))) begin
          state_nx = IDLE;
          row_nx   = COORD_W'(LAUNCH_ROW);
          col_nx   = '0;
        end else if (tick) begin
          row_nx = row - COORD_W'(STEP);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fly    = (state == FLY);
  assign active = fly && (col == pixel_column) && (pixel_row >= row) &&
                  ({1'b0, pixel_row} < ({1'b0, row} + (COORD_W+1)'(MISSILE_LEN)));

endmodule

// File: rtl/player_missile_bank.sv
// Pool of player missiles: fire synchroniser, motion tick, cooldown, slot allocation.
// Optional MISSILE_AUTOFIRE_EN: a held fire button re-fires each time cooldown expires.
module player_missile_bank
  import sprite_pkg::*;
#(
  parameter int unsigned N_MISSILES     = 3,
  parameter int unsigned TICK_CYCLES    = 1000000,
  parameter int unsigned STEP           = 2,
  parameter int unsigned MISSILE_LEN    = 3,
  parameter int unsigned LAUNCH_ROW     = 456,
  parameter int unsigned GUN_OFFSET     = 8,
  parameter int unsigned TOP_ROW        = 20,
  parameter int unsigned COOLDOWN_TICKS = 8
) (
  input logic            clk,
  input logic            rst,
  player_missile_bank_if.slave bus
);

  localparam int unsigned ID_W  = idx_w(N_MISSILES);
  localparam int unsigned CNT_W = idx_w(N_MISSILES + 1);
  localparam int unsigned TCK_W = idx_w(TICK_CYCLES);
  localparam int unsigned CD_W  = idx_w(COOLDOWN_TICKS + 1);

  logic                  sync1, sync2, sync_prev;
  logic [TCK_W-1:0]      tick_cnt;
  logic [CD_W-1:0]       cooldown;
  logic                  fire_accepted, fire_dropped;
  logic [CNT_W-1:0]      in_flight, fly_count;
  logic [N_MISSILES-1:0] fly_vec, active_vec, hit_vec, first_idle, launch_vec;
  logic                  tick, fire_edge, fire_req, idle_any, accept;
  logic [COORD_W-1:0]    launch_col;

  assign tick       = (tick_cnt == TCK_W'(TICK_CYCLES - 1));
  assign fire_edge  = sync2 && !sync_prev;
  assign launch_col = bus.player_col + COORD_W'(GUN_OFFSET);

`ifdef MISSILE_AUTOFIRE_EN
  logic cd_done;

  // Marks the first cycle with cooldown back at zero after a countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cd_done <= 1'b0;
    else      cd_done <= tick && (cooldown == CD_W'(1));
  end

  assign fire_req = fire_edge || (sync2 && cd_done);
`else
  assign fire_req = fire_edge;
`endif

  // Lowest-index IDLE slot, chosen from the states at the start of the cycle.
  always_comb begin
    first_idle = '0;
    idle_any   = 1'b0;
    for (int i = 0; i < int'(N_MISSILES); i++) begin
      if (!fly_vec[i] && !idle_any) begin
        first_idle[i] = 1'b1;
        idle_any      = 1'b1;
      end
    end
  end

  assign accept     = fire_req && (cooldown == '0) && idle_any;
  assign launch_vec = accept ? first_idle : '0;

  always_comb begin
    fly_count = '0;
    for (int i = 0; i < int'(N_MISSILES); i++) begin
      fly_count = fly_count + CNT_W'(fly_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      sync_prev     <= 1'b0;
      tick_cnt      <= '0;
      cooldown      <= '0;
      fire_accepted <= 1'b0;
      fire_dropped  <= 1'b0;
      in_flight     <= '0;
    end else begin
      sync1         <= bus.fire_btn;
      sync2         <= sync1;
      sync_prev     <= sync2;
      tick_cnt      <= tick ? '0 : tick_cnt + TCK_W'(1);
      fire_accepted <= accept;
      fire_dropped  <= fire_req && !accept;
      in_flight     <= fly_count;
      if (accept)                       cooldown <= CD_W'(COOLDOWN_TICKS);
      else if (tick && cooldown != '0)  cooldown <= cooldown - CD_W'(1);
    end
  end

  for (genvar g = 0; g < int'(N_MISSILES); g++) begin : g_slot
    assign hit_vec[g] = bus.hit_valid && (bus.hit_id == ID_W'(g));

    missile_slot #(
      .STEP        (STEP),
      .MISSILE_LEN (MISSILE_LEN),
      .LAUNCH_ROW  (LAUNCH_ROW),
      .TOP_ROW     (TOP_ROW)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .launch       (launch_vec[g]),
      .tick         (tick),
      .hit          (hit_vec[g]),
      .launch_col   (launch_col),
      .pixel_row    (bus.pixel_row),
      .pixel_column (bus.pixel_column),
      .fly          (fly_vec[g]),
      .active       (active_vec[g])
    );
  end

  assign bus.missile_active_vec = active_vec;
  assign bus.missile_output     = (|active_vec) ? PIX_ON : PIX_OFF;
  assign bus.fire_accepted      = fire_accepted;
  assign bus.fire_dropped       = fire_dropped;
  assign bus.in_flight          = in_flight;

endmodule

// File: tb/tb_player_missile_bank.sv
// Directed bench for player_missile_bank with a 4-cycle tick and 2-tick cooldown.
module tb_player_missile_bank;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  player_missile_bank_if #(.N_MISSILES(N)) bus ();

  player_missile_bank #(
    .N_MISSILES     (N),
    .TICK_CYCLES    (4),
    .STEP           (2),
    .MISSILE_LEN    (3),
    .LAUNCH_ROW     (456),
    .GUN_OFFSET     (8),
    .TOP_ROW        (20),
    .COOLDOWN_TICKS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int row;
    int col;
    int vec;
    int out;
  } pix_vec_t;

  pix_vec_t tbl[8];
  int total = 0;
  int bad   = 0;
  int edges = 0;
  int launch_at[3];
  int e_hit;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Rows move at every edge that is a multiple of 4 after the launch edge.
  function automatic int exp_row(input int l, input int e);
    return 456 - 2 * (e / 4 - l / 4);
  endfunction

  task automatic probe(input string name, input int row, input int col, input int vec);
    bus.pixel_row    = 12'(row);
    bus.pixel_column = 12'(col);
    #1;
    check({name, "_vec"}, int'(bus.missile_active_vec), vec);
    check({name, "_out"}, int'(bus.missile_output), (vec != 0) ? 15 : 0);
  endtask

  // One-cycle fire pulse; outcome is registered three edges later.
  task automatic press(input string name, input int acc, input int drp);
    bus.fire_btn = 1'b1;
    step();
    bus.fire_btn = 1'b0;
    step();
    step();
    check({name, "_acc"}, int'(bus.fire_accepted), acc);
    check({name, "_drop"}, int'(bus.fire_dropped), drp);
  endtask

  initial begin
    tbl[0] = '{456, 108, 1, 15};
    tbl[1] = '{457, 108, 1, 15};
    tbl[2] = '{458, 108, 1, 15};
    tbl[3] = '{459, 108, 0, 0};
    tbl[4] = '{455, 108, 0, 0};
    tbl[5] = '{456, 107, 0, 0};
    tbl[6] = '{456, 109, 0, 0};
    tbl[7] = '{458, 100, 0, 0};

    bus.pixel_row    = 12'd456;
    bus.pixel_column = 12'd0;
    bus.player_col   = 12'd0;
    bus.fire_btn     = 1'b0;
    bus.hit_valid    = 1'b0;
    bus.hit_id       = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", int'(bus.fire_accepted), 0);
    check("rst_drop", int'(bus.fire_dropped), 0);
    check("rst_inflight", int'(bus.in_flight), 0);
    check("rst_out", int'(bus.missile_output), 0);
    rst   = 1'b1;
    edges = 0;

    // First shot: fire high at cycle 10, accepted at cycle 13
    while (edges < 10) step();
    bus.player_col = 12'd100;
    bus.fire_btn   = 1'b1;
    step();
    check("lat11_acc", int'(bus.fire_accepted), 0);
    bus.fire_btn = 1'b0;
    step();
    check("lat12_acc", int'(bus.fire_accepted), 0);
    step();
    check("lat13_acc", int'(bus.fire_accepted), 1);
    check("lat13_drop", int'(bus.fire_dropped), 0);
    for (int i = 0; i < 8; i++) begin
      bus.pixel_row    = 12'(tbl[i].row);
      bus.pixel_column = 12'(tbl[i].col);
      #1;
      check($sformatf("tbl%0d_vec", i), int'(bus.missile_active_vec), tbl[i].vec);
      check($sformatf("tbl%0d_out", i), int'(bus.missile_output), tbl[i].out);
    end
    step();
    check("pulse_acc", int'(bus.fire_accepted), 0);
    check("inflight_one", int'(bus.in_flight), 1);

    // Flight to the top row and retirement
    while (edges < 884) begin
      step();
      if (edges % 4 == 0) probe("fly", exp_row(13, edges), 108, 1);
    end
    probe("top_row", 20, 108, 1);
    while (edges < 888) step();
    probe("retired", 20, 108, 0);
    probe("retired_low", 18, 108, 0);
    check("retire_inflight1", int'(bus.in_flight), 1);
    step();
    check("retire_inflight0", int'(bus.in_flight), 0);

    // Three spaced shots fill the pool; a fourth edge is dropped
    for (int s = 0; s < 3; s++) begin
      bus.player_col = 12'(100 + 100 * s);
      press($sformatf("shot%0d", s), 1, 0);
      launch_at[s] = edges;
      repeat (9) step();
    end
    check("full_inflight", int'(bus.in_flight), 3);
    press("fourth", 0, 1);
    for (int s = 0; s < 3; s++) begin
      probe($sformatf("keep%0d", s), exp_row(launch_at[s], edges), 108 + 100 * s, 1 << s);
    end
    step();
    check("fourth_inflight", int'(bus.in_flight), 3);
    check("fourth_pulse", int'(bus.fire_dropped), 0);

    // Hit on slot1 during a tick cycle beats the move
    while (edges % 4 != 3) step();
    e_hit          = edges;
    bus.hit_valid  = 1'b1;
    bus.hit_id     = 2'd1;
    step();
    bus.hit_valid  = 1'b0;
    probe("hit_old", exp_row(launch_at[1], e_hit), 208, 0);
    probe("hit_new", exp_row(launch_at[1], edges), 208, 0);
    probe("hit_slot0", exp_row(launch_at[0], edges), 108, 1);
    check("hit_inflight3", int'(bus.in_flight), 3);
    step();
    check("hit_inflight2", int'(bus.in_flight), 2);

    // Hits to an IDLE slot and to an out-of-range id are ignored
    bus.hit_valid = 1'b1;
    bus.hit_id    = 2'd1;
    step();
    bus.hit_id    = 2'd3;
    step();
    bus.hit_valid = 1'b0;
    step();
    check("ignored_inflight", int'(bus.in_flight), 2);
    probe("ignored_slot2", exp_row(launch_at[2], edges), 308, 4);

    // Two edges inside the cooldown window: lowest IDLE slot, then a drop
    bus.player_col = 12'd400;
    press("cd_first", 1, 0);
    probe("cd_slot1", 456, 408, 2);
    press("cd_second", 0, 1);
    check("cd_inflight", int'(bus.in_flight), 3);

    // Free slot2 to leave two missiles flying
    bus.hit_valid = 1'b1;
    bus.hit_id    = 2'd2;
    step();
    bus.hit_valid = 1'b0;
    step();
    check("two_inflight", int'(bus.in_flight), 2);

    // Asynchronous reset mid-flight clears everything at once
    bus.pixel_row    = 12'(exp_row(launch_at[0], edges));
    bus.pixel_column = 12'd108;
    #4;
    rst = 1'b0;
    #1;
    check("async_inflight", int'(bus.in_flight), 0);
    check("async_out", int'(bus.missile_output), 0);
    check("async_vec", int'(bus.missile_active_vec), 0);
    check("async_acc", int'(bus.fire_accepted), 0);
    #2;
    rst   = 1'b1;
    edges = 0;
    bus.player_col = 12'd50;
    press("post_rst", 1, 0);
    probe("post_rst_slot0", 456, 58, 1);
    step();
    check("post_rst_inflight", int'(bus.in_flight), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
